// File: rtl/display_loader_if.sv
// Digit/latch link between the time-keeping logic and display_loader.
// The loader takes the slave side; the frame source takes the master side.
interface display_loader_if;
  logic        load;
  logic [29:0] digits;
  logic        busy;
  logic        done;
  logic [4:0]  digit;
  logic        latch;

  modport master (output load, digits, input busy, done, digit, latch);
  modport slave  (input load, digits, output busy, done, digit, latch);
endinterface

// File: rtl/display_loader.sv
// Shifts a snapshotted six-digit frame to the display scanner, position 5 first,
// one setup/latch/hold sequence per digit. Define DISPLAY_LOADER_BLANK_EN for leading-zero blanking.
module display_loader #(
  parameter int unsigned LATCH_CYC  = 2,
  parameter logic [4:0]  BLANK_CODE = 5'h1F
) (
  input logic             clk,
  input logic             rst_n,
  display_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_e;

  localparam logic [7:0] CNT_RELOAD = 8'(LATCH_CYC - 1);
  localparam logic [2:0] FIRST_POS  = 3'd5;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [5:0][4:0] frame_q, frame_d;
  logic [4:0]      digit_q, digit_d;
  logic            latch_q, latch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            phase_end;
  logic            accept;

`ifdef DISPLAY_LOADER_BLANK_EN
  // Zeros stay blank until the first nonzero position from the left; position 0 always shows.
  function automatic logic [5:0][4:0] prep_frame(input logic [29:0] raw);
    logic [5:0][4:0] f;
    logic            leading;
    f       = raw;
    leading = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      if (leading && f[3'(k)] == 5'd0) begin
        f[3'(k)] = BLANK_CODE;
      end else begin
        leading = 1'b0;
      end
    end
    return f;
  endfunction
`else
  function automatic logic [5:0][4:0] prep_frame(input logic [29:0] raw);
    return raw;
  endfunction

  logic unused_blank_code;
  assign unused_blank_code = ^BLANK_CODE;
`endif

  assign phase_end = (cnt_q == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      digit_q <= '0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      digit_q <= digit_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // A new frame is taken from IDLE or on the very edge that ends the last hold phase.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: accept = bus.load;
      SETUP: begin
        if (phase_end) begin
          state_d = PULSE;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PULSE: begin
        if (phase_end) begin
          state_d = HOLD;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (!phase_end) begin
          cnt_d = cnt_q - 8'd1;
        end else if (idx_q != 3'd0) begin
          state_d = SETUP;
          idx_d   = idx_q - 3'd1;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = IDLE;
          accept  = bus.load;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = SETUP;
      idx_d   = FIRST_POS;
      cnt_d   = CNT_RELOAD;
      frame_d = prep_frame(bus.digits);
    end
  end

  // Outputs are registered from the next state, so done lands on the final hold cycle.
  always_comb begin
    busy_d  = (state_d != IDLE);
    latch_d = (state_d == PULSE);
    done_d  = (state_d == HOLD) && (idx_d == 3'd0) && (cnt_d == 8'd0);
    digit_d = digit_q;
    if (state_d == SETUP) begin
      digit_d = frame_d[idx_d];
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.digit = digit_q;
  assign bus.latch = latch_q;

endmodule

// File: tb/tb_display_loader.sv
// Randomised bench for display_loader against a cycle-count model of the frame timing,
// with a behavioural receiver that captures digit on each latch falling edge.
module tb_display_loader;

  localparam int LC        = 2;
  localparam int DIGIT_CYC = 3 * LC;
  localparam int FRAME_CYC = 18 * LC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  display_loader_if bus ();

  display_loader #(
    .LATCH_CYC (LC),
    .BLANK_CODE(5'h1F)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int passCount  = 0;
  int checkCount = 0;

  // Model: a frame is "k cycles old" after its accepting edge; everything follows from k.
  bit          mActive    = 1'b0;
  int          mK         = 0;
  logic [29:0] mFrame     = '0;
  logic [4:0]  mLastDigit = '0;

  logic [29:0] rxStages   = '0;
  logic [4:0]  capQ[$];
  logic        prevLatch  = 1'b0;
  int          fallCount  = 0;
  int          frameFalls = 0;
  int          doneSeen   = 0;
  logic        expLatch, expDone;

  function automatic logic [29:0] blankModel(input logic [29:0] raw);
    logic [29:0] r;
    r = raw;
`ifdef DISPLAY_LOADER_BLANK_EN
    begin
      bit seenNonzero;
      seenNonzero = 1'b0;
      for (int p = 5; p >= 1; p--) begin
        if (raw[5*p +: 5] != 5'd0) seenNonzero = 1'b1;
        else if (!seenNonzero) r[5*p +: 5] = 5'h1F;
      end
    end
`endif
    return r;
  endfunction

  function automatic logic [29:0] randDigits();
    logic [29:0] d;
    for (int p = 0; p < 6; p++) begin
      d[5*p +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    end
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input bit ld, input logic [29:0] dg, input bit rn);
    @(negedge clk);
    bus.load   = ld;
    bus.digits = dg;
    rst_n      = rn;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      mActive    = 1'b0;
      mK         = 0;
      mFrame     = '0;
      mLastDigit = '0;
    end else if (mActive && mK < FRAME_CYC - 1) begin
      mK++;
    end else if (bus.load) begin
      mActive = 1'b1;
      mK      = 0;
      mFrame  = blankModel(bus.digits);
    end else begin
      mActive = 1'b0;
    end
    if (mActive) mLastDigit = mFrame[5*(5 - mK / DIGIT_CYC) +: 5];
  end

  // Per-cycle compare plus the receiver that the scanner would be.
  always @(negedge clk) begin
    expLatch = mActive && ((mK % DIGIT_CYC) / LC == 1);
    expDone  = mActive && (mK == FRAME_CYC - 1);
    checkOutput("busy", bus.busy, mActive);
    checkOutput("latch", bus.latch, expLatch);
    checkOutput("done", bus.done, expDone);
    checkOutput("digit", bus.digit, mLastDigit);
    if (mActive && mK == 0) frameFalls = 0;
    if (prevLatch === 1'b1 && bus.latch === 1'b0) begin
      rxStages = {rxStages[24:0], bus.digit};
      capQ.push_back(bus.digit);
      fallCount++;
      frameFalls++;
    end
    prevLatch = bus.latch;
    if (expDone) begin
      checkOutput("fallsPerFrame", frameFalls, 6);
      checkOutput("rxStages", rxStages, mFrame);
      doneSeen++;
    end
  end

  task automatic runFrame(input logic [29:0] dg, input int spamA, input int spamB, output int cycles);
    bit got;
    got    = 1'b0;
    cycles = 0;
    capQ.delete();
    applyStimulus(1'b1, dg, 1'b1);
    while (!got && cycles < 4 * FRAME_CYC) begin
      cycles++;
      if (cycles == spamA || cycles == spamB) applyStimulus(1'b1, ~dg, 1'b1);
      else applyStimulus(1'b0, dg, 1'b1);
      if (bus.done) got = 1'b1;
    end
    if (!got) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (bus.busy && n < 4 * FRAME_CYC) begin
      applyStimulus(1'b0, bus.digits, 1'b1);
      n++;
    end
    if (bus.busy) checkOutput("idleTimeout", 32'd0, 32'd1);
    applyStimulus(1'b0, bus.digits, 1'b1);
  endtask

  task automatic checkSeq(input string tag, input logic [4:0] expSeq[6]);
    checkOutput({tag, "_count"}, capQ.size(), 6);
    for (int i = 0; i < 6 && i < capQ.size(); i++) begin
      checkOutput({tag, "_digit"}, capQ[i], expSeq[i]);
    end
  endtask

  logic [29:0] frameA, frameB;
  logic [4:0]  seqExp[6];
  int          cyc, zeroBusy, heldDones, doneCount;

  initial begin
    bus.load   = 1'b0;
    bus.digits = '0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstLatch", bus.latch, 0);
    checkOutput("rstBusy", bus.busy, 0);
    checkOutput("rstDone", bus.done, 0);
    checkOutput("rstDigit", bus.digit, 0);

    repeat (50) applyStimulus(1'b0, 30'($urandom), 1'b1);
    checkOutput("idleFalls", fallCount, 0);
    checkOutput("idleBusy", bus.busy, 0);

    $display("[TB] single frame 1..6");
    frameA = {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    runFrame(frameA, -1, -1, cyc);
    checkOutput("doneLatency", cyc, 36);
    seqExp = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
    checkSeq("seq123456", seqExp);
    checkOutput("rxStagePos", rxStages, frameA);
    applyStimulus(1'b0, frameA, 1'b1);
    checkOutput("busyAfterDone", bus.busy, 0);

    $display("[TB] load while busy");
    frameB = {5'd9, 5'd8, 5'd17, 5'd30, 5'd2, 5'd11};
    runFrame(frameB, 5, 20, cyc);
    seqExp = '{5'd9, 5'd8, 5'd17, 5'd30, 5'd2, 5'd11};
    checkSeq("seqIgnoreLoad", seqExp);
    waitIdle();

    $display("[TB] load held high");
    zeroBusy  = 0;
    heldDones = 0;
    applyStimulus(1'b1, randDigits(), 1'b1);
    for (int c = 0; c < 2 * FRAME_CYC; c++) begin
      applyStimulus(1'b1, randDigits(), 1'b1);
      if (!bus.busy) zeroBusy++;
      if (bus.done) heldDones++;
    end
    checkOutput("heldBusyGap", zeroBusy, 0);
    checkOutput("heldDones", heldDones, 2);
    applyStimulus(1'b0, randDigits(), 1'b1);
    waitIdle();

    $display("[TB] reset in third digit pulse");
    frameA = {5'd3, 5'd14, 5'd15, 5'd9, 5'd26, 5'd5};
    doneCount = 0;
    applyStimulus(1'b1, frameA, 1'b1);
    for (int c = 1; c <= 14; c++) applyStimulus(1'b0, frameA, 1'b1);
    @(negedge clk);
    checkOutput("pulse3Latch", bus.latch, 1);
    checkOutput("pulse3Digit", bus.digit, 5'd15);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("latchAfterReset", bus.latch, 0);
    checkOutput("busyAfterReset", bus.busy, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, frameA, 1'b1);
      if (bus.done) doneCount++;
    end
    checkOutput("noDoneAfterReset", doneCount, 0);
    frameB = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2};
    runFrame(frameB, -1, -1, cyc);
    seqExp = '{5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2};
    checkSeq("seqAfterReset", seqExp);
    checkOutput("rxAfterReset", rxStages, frameB);
    waitIdle();

`ifdef DISPLAY_LOADER_BLANK_EN
    $display("[TB] leading-zero blanking");
    runFrame({5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0}, -1, -1, cyc);
    seqExp = '{5'h1F, 5'h1F, 5'd1, 5'd0, 5'd0, 5'd0};
    checkSeq("seqBlank", seqExp);
    waitIdle();
    runFrame(30'd0, -1, -1, cyc);
    seqExp = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'd0};
    checkSeq("seqAllZero", seqExp);
    waitIdle();
`endif

    $display("[TB] random traffic");
    for (int c = 0; c < 2500; c++) begin
      applyStimulus($urandom_range(0, 9) == 0, randDigits(), $urandom_range(0, 299) != 0);
    end
    applyStimulus(1'b0, '0, 1'b1);
    waitIdle();
    repeat (5) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("randomFramesSeen", doneSeen > 10, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
